// File: rtl/calc_pkg.sv
// Shared types and constants for the two-operand BCD calculator sequencer.
// Provides the entry-step state enum, operator codes, result width and
// small BCD helpers used by calc_seq_ctrl.
package calc_pkg;

  localparam int RES_W = 14;

  typedef enum logic [2:0] {
    A_TENS   = 3'd0,
    A_ONES   = 3'd1,
    SEL_OP   = 3'd2,
    B_TENS   = 3'd3,
    B_ONES   = 3'd4,
    SHOW_RES = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } op_t;

  // One BCD digit step, wrapping 9 -> 0.
  function automatic logic [3:0] bcd_inc(input logic [3:0] d);
    return (d >= 4'd9) ? 4'd0 : d + 4'd1;
  endfunction

  // Two BCD digits to binary 0..99.
  function automatic logic [6:0] bcd_val(input logic [3:0] tens, input logic [3:0] ones);
    return ({3'b000, tens} * 7'd10) + {3'b000, ones};
  endfunction

endpackage

// File: rtl/btn_edge.sv
// Button front end: SYNC_STAGES-deep synchronizer followed by a 0->1 edge
// detector. rise is a single-cycle pulse per press, however long the
// button is held.
module btn_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   prev_reg;

  // Shift the raw button in and remember the last synchronized level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_reg <= '0;
      prev_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], btn};
      prev_reg <= sync_reg[SYNC_STAGES-1];
    end
  end

  assign rise = sync_reg[SYNC_STAGES-1] & ~prev_reg;

endmodule

// File: rtl/calc_seq_ctrl.sv
// Calculator entry sequencer: steps through A tens/ones, operator, B
// tens/ones and a result display, driven by three debounced-by-sync
// buttons (inc, next, clr; clr has highest priority, then next).
// Optional build macro CALC_DIV_EN adds the DIV operator and its divider.
module calc_seq_ctrl
  import calc_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_inc,
  input  logic             btn_next,
  input  logic             btn_clr,
  output logic [3:0]       a_tens,
  output logic [3:0]       a_ones,
  output logic [3:0]       b_tens,
  output logic [3:0]       b_ones,
  output logic [1:0]       op,
  output logic [2:0]       state,
  output logic [RES_W-1:0] result,
  output logic             res_neg,
  output logic             res_err,
  output logic             res_valid
);

  // Bit order: 0 = inc, 1 = next, 2 = clr.
  logic [2:0] btn_vec;
  logic [2:0] rise_vec;
  logic       rise_inc;
  logic       rise_next;
  logic       rise_clr;

  assign btn_vec   = {btn_clr, btn_next, btn_inc};
  assign rise_inc  = rise_vec[0];
  assign rise_next = rise_vec[1];
  assign rise_clr  = rise_vec[2];

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_btn
      btn_edge #(
        .SYNC_STAGES(SYNC_STAGES)
      ) u_btn_edge (
        .clk (clk),
        .rst (rst),
        .btn (btn_vec[gi]),
        .rise(rise_vec[gi])
      );
    end
  endgenerate

  state_t           state_reg, state_next;
  logic [3:0]       a_tens_reg, a_tens_next;
  logic [3:0]       a_ones_reg, a_ones_next;
  logic [3:0]       b_tens_reg, b_tens_next;
  logic [3:0]       b_ones_reg, b_ones_next;
  op_t              op_reg, op_next;
  logic [RES_W-1:0] result_reg, result_next;
  logic             res_neg_reg, res_neg_next;
  logic             res_err_reg, res_err_next;
  logic             res_valid_reg, res_valid_next;

  logic [6:0]       a_val;
  logic [6:0]       b_val;
  logic [RES_W-1:0] calc_res;
  logic             calc_neg;
  logic             calc_err;
  op_t              op_cycled;

  assign a_val = bcd_val(a_tens_reg, a_ones_reg);
  assign b_val = bcd_val(b_tens_reg, b_ones_reg);

  // Arithmetic on the entered operands; only captured on B_ONES -> SHOW_RES.
  always_comb begin
    calc_res = '0;
    calc_neg = 1'b0;
    calc_err = 1'b0;
    case (op_reg)
      OP_ADD: calc_res = RES_W'(a_val) + RES_W'(b_val);
      OP_SUB: begin
        if (a_val < b_val) begin
          calc_res = RES_W'(b_val - a_val);
          calc_neg = 1'b1;
        end else begin
          calc_res = RES_W'(a_val - b_val);
        end
      end
      OP_MUL: calc_res = RES_W'(a_val) * RES_W'(b_val);
`ifdef CALC_DIV_EN
      OP_DIV: begin
        if (b_val == 7'd0) begin
          calc_err = 1'b1;
        end else begin
          calc_res = RES_W'(a_val / b_val);
        end
      end
`endif
      default: calc_res = '0;
    endcase
  end

  // Operator cycle order; DIV joins the ring only when built in.
  always_comb begin
`ifdef CALC_DIV_EN
    op_cycled = op_t'(op_reg + 2'd1);
`else
    op_cycled = (op_reg == OP_MUL) ? OP_ADD : op_t'(op_reg + 2'd1);
`endif
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= A_TENS;
      a_tens_reg    <= '0;
      a_ones_reg    <= '0;
      b_tens_reg    <= '0;
      b_ones_reg    <= '0;
      op_reg        <= OP_ADD;
      result_reg    <= '0;
      res_neg_reg   <= 1'b0;
      res_err_reg   <= 1'b0;
      res_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      a_tens_reg    <= a_tens_next;
      a_ones_reg    <= a_ones_next;
      b_tens_reg    <= b_tens_next;
      b_ones_reg    <= b_ones_next;
      op_reg        <= op_next;
      result_reg    <= result_next;
      res_neg_reg   <= res_neg_next;
      res_err_reg   <= res_err_next;
      res_valid_reg <= res_valid_next;
    end
  end

  // Next-state: clr beats next beats inc; only the winning edge acts.
  always_comb begin
    state_next     = state_reg;
    a_tens_next    = a_tens_reg;
    a_ones_next    = a_ones_reg;
    b_tens_next    = b_tens_reg;
    b_ones_next    = b_ones_reg;
    op_next        = op_reg;
    result_next    = result_reg;
    res_neg_next   = res_neg_reg;
    res_err_next   = res_err_reg;
    res_valid_next = res_valid_reg;

    if (rise_clr || (rise_next && state_reg == SHOW_RES)) begin
      state_next     = A_TENS;
      a_tens_next    = '0;
      a_ones_next    = '0;
      b_tens_next    = '0;
      b_ones_next    = '0;
      op_next        = OP_ADD;
      result_next    = '0;
      res_neg_next   = 1'b0;
      res_err_next   = 1'b0;
      res_valid_next = 1'b0;
    end else if (rise_next) begin
      state_next = state_t'(state_reg + 3'd1);
      if (state_reg == B_ONES) begin
        result_next    = calc_res;
        res_neg_next   = calc_neg;
        res_err_next   = calc_err;
        res_valid_next = 1'b1;
      end
    end else if (rise_inc) begin
      case (state_reg)
        A_TENS:  a_tens_next = bcd_inc(a_tens_reg);
        A_ONES:  a_ones_next = bcd_inc(a_ones_reg);
        SEL_OP:  op_next     = op_cycled;
        B_TENS:  b_tens_next = bcd_inc(b_tens_reg);
        B_ONES:  b_ones_next = bcd_inc(b_ones_reg);
        default: ;
      endcase
    end
  end

  assign a_tens    = a_tens_reg;
  assign a_ones    = a_ones_reg;
  assign b_tens    = b_tens_reg;
  assign b_ones    = b_ones_reg;
  assign op        = op_reg;
  assign state     = state_reg;
  assign result    = result_reg;
  assign res_neg   = res_neg_reg;
  assign res_err   = res_err_reg;
  assign res_valid = res_valid_reg;

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// Scoreboard bench for calc_seq_ctrl: stimulus pushes expected snapshots and
// results into queues; a monitor pops and compares them on the falling edge.
module tb_calc_seq_ctrl;

  localparam int SYNC  = 2;
  localparam int HOLD  = SYNC + 3;
  localparam int GAP   = SYNC + 3;
  localparam int LIMIT = 60000;

  localparam logic [2:0] INC = 3'b001;
  localparam logic [2:0] NXT = 3'b010;
  localparam logic [2:0] CLR = 3'b100;

  logic        clk;
  logic        rst;
  logic        btn_inc, btn_next, btn_clr;
  logic [3:0]  a_tens, a_ones, b_tens, b_ones;
  logic [1:0]  op;
  logic [2:0]  state;
  logic [13:0] result;
  logic        res_neg, res_err, res_valid;

  calc_seq_ctrl #(.SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst(rst),
    .btn_inc(btn_inc), .btn_next(btn_next), .btn_clr(btn_clr),
    .a_tens(a_tens), .a_ones(a_ones), .b_tens(b_tens), .b_ones(b_ones),
    .op(op), .state(state), .result(result),
    .res_neg(res_neg), .res_err(res_err), .res_valid(res_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  st;
    logic [3:0]  at, ao, bt, bo;
    logic [1:0]  op;
    logic [13:0] res;
    logic        neg, err, val;
  } snap_t;

  typedef struct packed {
    logic [13:0] res;
    logic        neg, err;
  } res_t;

  snap_t snap_q[$];
  string snap_nm_q[$];
  res_t  res_q[$];
  string res_nm_q[$];

  int  snap_req = 0;
  bit  done     = 1'b0;
  int  vectors  = 0;
  int  miscompares = 0;

  // ---------------- stimulus ----------------
  task automatic press(input logic [2:0] which);
    @(negedge clk);
    {btn_clr, btn_next, btn_inc} = which;
    repeat (HOLD) @(negedge clk);
    {btn_clr, btn_next, btn_inc} = 3'b000;
    repeat (GAP) @(negedge clk);
  endtask

  task automatic press_n(input logic [2:0] which, input int n);
    for (int i = 0; i < n; i++) press(which);
  endtask

  task automatic snap(input string nm, input logic [2:0] st,
                      input logic [3:0] at, input logic [3:0] ao,
                      input logic [3:0] bt, input logic [3:0] bo,
                      input logic [1:0] o, input logic [13:0] r,
                      input logic ng, input logic er, input logic vl);
    snap_t s;
    #1;
    s = '{st: st, at: at, ao: ao, bt: bt, bo: bo, op: o, res: r, neg: ng, err: er, val: vl};
    snap_q.push_back(s);
    snap_nm_q.push_back(nm);
    snap_req++;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic snap_zero(input string nm);
    snap(nm, 3'd0, 4'd0, 4'd0, 4'd0, 4'd0, 2'd0, 14'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic expect_res(input string nm, input logic [13:0] r,
                            input logic ng, input logic er);
    res_q.push_back('{res: r, neg: ng, err: er});
    res_nm_q.push_back(nm);
  endtask

  // Walk A tens/ones, operator, B tens/ones; leaves the DUT in B_ONES.
  task automatic enter(input int at, input int ao, input int opn,
                       input int bt, input int bo);
    press_n(INC, at); press(NXT);
    press_n(INC, ao); press(NXT);
    press_n(INC, opn); press(NXT);
    press_n(INC, bt); press(NXT);
    press_n(INC, bo);
  endtask

  initial begin
    rst = 1'b1;
    {btn_clr, btn_next, btn_inc} = 3'b000;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    snap_zero("reset_state");

    // next and inc together: next wins, digit untouched
    press(NXT | INC);
    snap("next_beats_inc", 3'd1, 4'd0, 4'd0, 4'd0, 4'd0, 2'd0, 14'd0, 1'b0, 1'b0, 1'b0);
    press(CLR);
    snap_zero("clr_from_a_ones");

    // 12 + 34
    enter(1, 2, 0, 3, 4);
    snap("entry_12_add_34", 3'd4, 4'd1, 4'd2, 4'd3, 4'd4, 2'd0, 14'd0, 1'b0, 1'b0, 1'b0);
    expect_res("add_12_34", 14'd46, 1'b0, 1'b0);
    press(NXT);
    press(INC);
    snap("inc_ignored_in_show", 3'd5, 4'd1, 4'd2, 4'd3, 4'd4, 2'd0, 14'd46, 1'b0, 1'b0, 1'b1);
    press(NXT);
    snap_zero("next_from_show");

    // 05 - 37 (negative)
    enter(0, 5, 1, 3, 7);
    expect_res("sub_05_37", 14'd32, 1'b1, 1'b0);
    press(NXT);
    snap("show_sub_neg", 3'd5, 4'd0, 4'd5, 4'd3, 4'd7, 2'd1, 14'd32, 1'b1, 1'b0, 1'b1);
    press(NXT);

    // 50 - 08 (non-negative)
    enter(5, 0, 1, 0, 8);
    expect_res("sub_50_08", 14'd42, 1'b0, 1'b0);
    press(NXT);
    press(NXT);

    // 99 * 99, then a_tens wrap
    enter(9, 9, 2, 9, 9);
    expect_res("mul_99_99", 14'd9801, 1'b0, 1'b0);
    press(NXT);
    press(NXT);
    press_n(INC, 3);
    snap("a_tens_three", 3'd0, 4'd3, 4'd0, 4'd0, 4'd0, 2'd0, 14'd0, 1'b0, 1'b0, 1'b0);
    press_n(INC, 7);
    snap_zero("a_tens_wrap");

    // operator ring after three steps
    press_n(NXT, 2);
    press_n(INC, 3);
`ifdef CALC_DIV_EN
    snap("op_ring_3", 3'd2, 4'd0, 4'd0, 4'd0, 4'd0, 2'd3, 14'd0, 1'b0, 1'b0, 1'b0);
`else
    snap("op_ring_3", 3'd2, 4'd0, 4'd0, 4'd0, 4'd0, 2'd0, 14'd0, 1'b0, 1'b0, 1'b0);
`endif
    press(CLR);

    // clr and next together in B_TENS
    press_n(INC, 2); press(NXT);
    press(INC); press(NXT);
    press_n(INC, 2); press(NXT);
    press_n(INC, 4);
    snap("b_tens_loaded", 3'd3, 4'd2, 4'd1, 4'd4, 4'd0, 2'd2, 14'd0, 1'b0, 1'b0, 1'b0);
    press(CLR | NXT);
    snap_zero("clr_beats_next");

    // async reset mid-cycle in B_ONES
    press_n(INC, 7);
    press_n(NXT, 4);
    snap("b_ones_a7", 3'd4, 4'd7, 4'd0, 4'd0, 4'd0, 2'd0, 14'd0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    snap_zero("async_reset");
    // button held across reset release gives exactly one action
    btn_inc = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (HOLD + 2) @(negedge clk);
    btn_inc = 1'b0;
    repeat (GAP) @(negedge clk);
    snap("held_across_reset", 3'd0, 4'd1, 4'd0, 4'd0, 4'd0, 2'd0, 14'd0, 1'b0, 1'b0, 1'b0);
    press(CLR);

`ifdef CALC_DIV_EN
    enter(8, 4, 3, 0, 0);
    expect_res("div_84_00", 14'd0, 1'b0, 1'b1);
    press(NXT);
    press(NXT);
    enter(8, 4, 3, 0, 5);
    expect_res("div_84_05", 14'd16, 1'b0, 1'b0);
    press(NXT);
    press(NXT);
`endif
    snap_zero("final_idle");
    done = 1'b1;
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    int    snap_seen;
    int    cycles;
    logic  valid_prev;
    snap_t act;
    snap_t exp_s;
    res_t  exp_r;
    string nm;
    snap_seen  = 0;
    cycles     = 0;
    valid_prev = 1'b0;
    forever begin
      @(negedge clk);
      cycles++;
      if (snap_req != snap_seen) begin
        snap_seen++;
        vectors++;
        act = '{st: state, at: a_tens, ao: a_ones, bt: b_tens, bo: b_ones,
                op: op, res: result, neg: res_neg, err: res_err, val: res_valid};
        if (snap_q.size() == 0) begin
          miscompares++;
          $display("FAIL snapshot_queue: got request, required queued expectation");
        end else begin
          exp_s = snap_q.pop_front();
          nm    = snap_nm_q.pop_front();
          if (act !== exp_s) begin
            miscompares++;
            $display("FAIL %s: got st=%0d a=%0d%0d b=%0d%0d op=%0d res=%0d neg=%0b err=%0b val=%0b, required st=%0d a=%0d%0d b=%0d%0d op=%0d res=%0d neg=%0b err=%0b val=%0b",
                     nm, act.st, act.at, act.ao, act.bt, act.bo, act.op, act.res, act.neg, act.err, act.val,
                     exp_s.st, exp_s.at, exp_s.ao, exp_s.bt, exp_s.bo, exp_s.op, exp_s.res, exp_s.neg, exp_s.err, exp_s.val);
          end else begin
            $display("vector %s ok: st=%0d a=%0d%0d b=%0d%0d op=%0d res=%0d",
                     nm, act.st, act.at, act.ao, act.bt, act.bo, act.op, act.res);
          end
        end
      end
      if (res_valid && !valid_prev) begin
        vectors++;
        if (res_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_result: got res=%0d neg=%0b err=%0b, required none", result, res_neg, res_err);
        end else begin
          exp_r = res_q.pop_front();
          nm    = res_nm_q.pop_front();
          if (result !== exp_r.res || res_neg !== exp_r.neg || res_err !== exp_r.err || state !== 3'd5) begin
            miscompares++;
            $display("FAIL %s: got st=%0d res=%0d neg=%0b err=%0b, required st=5 res=%0d neg=%0b err=%0b",
                     nm, state, result, res_neg, res_err, exp_r.res, exp_r.neg, exp_r.err);
          end else begin
            $display("vector %s ok: res=%0d neg=%0b err=%0b", nm, result, res_neg, res_err);
          end
        end
      end
      valid_prev = res_valid;
      if (done) begin
        vectors++;
        if (snap_q.size() != 0 || res_q.size() != 0) begin
          miscompares++;
          $display("FAIL drain: got %0d snapshots and %0d results outstanding, required 0 and 0",
                   snap_q.size(), res_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
      end
      if (cycles > LIMIT) begin
        miscompares++;
        $display("FAIL timeout: got %0d cycles, required completion within %0d", cycles, LIMIT);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
      end
    end
  end

endmodule
